// File: rtl/alarm_pkg.sv
// Shared types and constants for the alarm-clock time-setting logic.
package alarm_pkg;

  localparam int unsigned DIGIT_W    = 4;
  localparam int unsigned NUM_DIGITS = 4;

  // Edit-cycle states; order follows the front-panel mode sequence.
  typedef enum logic [2:0] {
    ST_RUN     = 3'd0,
    ST_EDIT_HT = 3'd1,
    ST_EDIT_HU = 3'd2,
    ST_EDIT_MT = 3'd3,
    ST_EDIT_MU = 3'd4
  } set_state_t;

  // Per-digit wrap limits.
  localparam logic [DIGIT_W-1:0] HRT_MAX     = 4'd2;
  localparam logic [DIGIT_W-1:0] HRU_MAX     = 4'd9;
  localparam logic [DIGIT_W-1:0] HRU_MAX_20S = 4'd3;
  localparam logic [DIGIT_W-1:0] MINT_MAX    = 4'd5;
  localparam logic [DIGIT_W-1:0] MINU_MAX    = 4'd9;

  // Bit positions within the blank mask and the strobe vector.
  localparam int unsigned IDX_HRT  = 3;
  localparam int unsigned IDX_HRU  = 2;
  localparam int unsigned IDX_MINT = 1;
  localparam int unsigned IDX_MINU = 0;

  // Successor state on a mode edge.
  function automatic set_state_t next_edit_state(input set_state_t s);
    set_state_t n;
    case (s)
      ST_RUN:     n = ST_EDIT_HT;
      ST_EDIT_HT: n = ST_EDIT_HU;
      ST_EDIT_HU: n = ST_EDIT_MT;
      ST_EDIT_MT: n = ST_EDIT_MU;
      default:    n = ST_RUN;
    endcase
    return n;
  endfunction

  // One-hot mask of the digit edited in a state; zero in RUN.
  function automatic logic [NUM_DIGITS-1:0] edit_mask(input set_state_t s);
    logic [NUM_DIGITS-1:0] m;
    m = '0;
    case (s)
      ST_EDIT_HT: m[IDX_HRT]  = 1'b1;
      ST_EDIT_HU: m[IDX_HRU]  = 1'b1;
      ST_EDIT_MT: m[IDX_MINT] = 1'b1;
      ST_EDIT_MU: m[IDX_MINU] = 1'b1;
      default:    m = '0;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/btn_edge.sv
// Rising-edge pulse generator for a debounced, synchronized button level.
module btn_edge (
  input  logic clk,
  input  logic resetn,
  input  logic btn,
  output logic rise_c
);

  logic prev;
  logic armed;

  // Track the previous level; armed stays low for the first cycle after
  // reset so a button held through reset release never produces an edge.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      prev  <= 1'b0;
      armed <= 1'b0;
    end else begin
      prev  <= btn;
      armed <= 1'b1;
    end
  end

  assign rise_c = armed & btn & ~prev;

endmodule

// File: rtl/time_set_ctrl.sv
// Front-panel time-setting controller: edit-state sequencing, digit load
// strobes with wrap limits, blink masks and edit timeout.
module time_set_ctrl
  import alarm_pkg::*;
#(
  parameter int unsigned TIMEOUT_TICKS = 16
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       mode_btn,
  input  logic       up_btn,
  input  logic       blink_tick,
  input  logic [3:0] hrT_q,
  input  logic [3:0] hrU_q,
  input  logic [3:0] minT_q,
  input  logic [3:0] minU_q,
  output logic       set_hrT,
  output logic       set_hrU,
  output logic       set_minT,
  output logic       set_minU,
  output logic [3:0] new_val,
  output logic       run_en,
  output logic [3:0] blank
);

  localparam int unsigned TW = $clog2(TIMEOUT_TICKS + 1);
  localparam logic [TW-1:0] TO_LIMIT = TW'(TIMEOUT_TICKS);

  logic mode_rise;
  logic up_rise;

  set_state_t            state, state_nxt;
  logic                  phase, phase_nxt;
  logic [TW-1:0]         tcount, tcount_nxt;
  logic [NUM_DIGITS-1:0] set_q, set_nxt;
  logic [DIGIT_W-1:0]    new_val_q, new_val_nxt;
  logic [NUM_DIGITS-1:0] blank_q, blank_nxt;
  logic                  run_en_q, run_en_nxt;
  logic                  timeout_hit;
  logic                  state_chg;
  logic [DIGIT_W-1:0]    hru_lim;

  btn_edge u_mode_edge (
    .clk    (clk),
    .resetn (resetn),
    .btn    (mode_btn),
    .rise_c (mode_rise)
  );

  btn_edge u_up_edge (
    .clk    (clk),
    .resetn (resetn),
    .btn    (up_btn),
    .rise_c (up_rise)
  );

  // Increment with wrap; anything at or past the limit reloads zero.
  function automatic logic [DIGIT_W-1:0] wrap_inc(input logic [DIGIT_W-1:0] cur,
                                                  input logic [DIGIT_W-1:0] lim);
    return (cur >= lim) ? '0 : cur + DIGIT_W'(1);
  endfunction

  assign hru_lim = (hrT_q == HRT_MAX) ? HRU_MAX_20S : HRU_MAX;

  // Next-state, strobe, timeout and blink decode.
  always_comb begin
    state_nxt   = state;
    set_nxt     = '0;
    new_val_nxt = '0;
    timeout_hit = (tcount == TO_LIMIT);

    if (state == ST_RUN) begin
      if (mode_rise) state_nxt = ST_EDIT_HT;
    end else if (mode_rise) begin
      state_nxt = next_edit_state(state);
      // Clamp an hour-units value that is illegal for the 20s hours.
      if (state == ST_EDIT_HT && hrT_q == HRT_MAX && hrU_q > HRU_MAX_20S) begin
        set_nxt[IDX_HRU] = 1'b1;
        new_val_nxt      = HRU_MAX_20S;
      end
    end else if (up_rise) begin
      case (state)
        ST_EDIT_HT: begin
          set_nxt[IDX_HRT] = 1'b1;
          new_val_nxt      = wrap_inc(hrT_q, HRT_MAX);
        end
        ST_EDIT_HU: begin
          set_nxt[IDX_HRU] = 1'b1;
          new_val_nxt      = wrap_inc(hrU_q, hru_lim);
        end
        ST_EDIT_MT: begin
          set_nxt[IDX_MINT] = 1'b1;
          new_val_nxt       = wrap_inc(minT_q, MINT_MAX);
        end
        ST_EDIT_MU: begin
          set_nxt[IDX_MINU] = 1'b1;
          new_val_nxt       = wrap_inc(minU_q, MINU_MAX);
        end
        default: begin
          set_nxt     = '0;
          new_val_nxt = '0;
        end
      endcase
    end else if (timeout_hit) begin
      state_nxt = ST_RUN;
    end

    state_chg = (state_nxt != state);
    phase_nxt = state_chg ? 1'b0 : (phase ^ blink_tick);

    if (state_chg || mode_rise || up_rise || state == ST_RUN) begin
      tcount_nxt = '0;
    end else if (blink_tick && !timeout_hit) begin
      tcount_nxt = tcount + TW'(1);
    end else begin
      tcount_nxt = tcount;
    end

    blank_nxt  = phase_nxt ? edit_mask(state_nxt) : '0;
    run_en_nxt = (state_nxt == ST_RUN);
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state     <= ST_RUN;
      phase     <= 1'b0;
      tcount    <= '0;
      set_q     <= '0;
      new_val_q <= '0;
      blank_q   <= '0;
      run_en_q  <= 1'b1;
    end else begin
      state     <= state_nxt;
      phase     <= phase_nxt;
      tcount    <= tcount_nxt;
      set_q     <= set_nxt;
      new_val_q <= new_val_nxt;
      blank_q   <= blank_nxt;
      run_en_q  <= run_en_nxt;
    end
  end

  assign set_hrT  = set_q[IDX_HRT];
  assign set_hrU  = set_q[IDX_HRU];
  assign set_minT = set_q[IDX_MINT];
  assign set_minU = set_q[IDX_MINU];
  assign new_val  = new_val_q;
  assign blank    = blank_q;
  assign run_en   = run_en_q;

endmodule

// File: tb/tb_time_set_ctrl.sv
// Directed bench for time_set_ctrl.
module tb_time_set_ctrl;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       mode_btn = 1'b0;
  logic       up_btn = 1'b0;
  logic       blink_tick = 1'b0;
  logic [3:0] hrT_q, hrU_q, minT_q, minU_q;
  logic       set_hrT, set_hrU, set_minT, set_minU;
  logic [3:0] new_val;
  logic       run_en;
  logic [3:0] blank;
  logic [3:0] sets;

  int vectors = 0;
  int miscompares = 0;

  time_set_ctrl #(.TIMEOUT_TICKS(16)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .mode_btn   (mode_btn),
    .up_btn     (up_btn),
    .blink_tick (blink_tick),
    .hrT_q      (hrT_q),
    .hrU_q      (hrU_q),
    .minT_q     (minT_q),
    .minU_q     (minU_q),
    .set_hrT    (set_hrT),
    .set_hrU    (set_hrU),
    .set_minT   (set_minT),
    .set_minU   (set_minU),
    .new_val    (new_val),
    .run_en     (run_en),
    .blank      (blank)
  );

  always #5 clk = ~clk;

  assign sets = {set_hrT, set_hrU, set_minT, set_minU};

  task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press_mode();
    mode_btn = 1'b1;
    @(negedge clk);
  endtask

  task automatic press_up();
    up_btn = 1'b1;
    @(negedge clk);
  endtask

  task automatic release_btns();
    mode_btn = 1'b0;
    up_btn   = 1'b0;
    @(negedge clk);
  endtask

  task automatic do_tick();
    blink_tick = 1'b1;
    @(negedge clk);
    blink_tick = 1'b0;
  endtask

  logic [3:0] walk_mask [4];

  initial begin
    walk_mask[0] = 4'b1000;
    walk_mask[1] = 4'b0100;
    walk_mask[2] = 4'b0010;
    walk_mask[3] = 4'b0001;
    hrT_q = 4'd1; hrU_q = 4'd5; minT_q = 4'd3; minU_q = 4'd4;

    // Reset state
    cyc(2);
    check("rst_run_en",  4'(run_en), 4'h1);
    check("rst_sets",    sets,       4'h0);
    check("rst_new_val", new_val,    4'h0);
    check("rst_blank",   blank,      4'h0);
    resetn = 1'b1;
    cyc(2);

    // Walk through every edit state; a blink tick exposes which digit is edited
    for (int i = 0; i < 4; i++) begin
      press_mode();
      check("walk_run_en", 4'(run_en), 4'h0);
      check("walk_sets",   sets,       4'h0);
      release_btns();
      do_tick();
      check("walk_blank",  blank, walk_mask[i]);
      cyc(1);
    end
    press_mode();
    check("walk_back_run_en", 4'(run_en), 4'h1);
    check("walk_back_blank",  blank,      4'h0);
    check("walk_back_sets",   sets,       4'h0);
    release_btns();

    // Up in RUN is ignored
    press_up();
    check("run_up_sets",    sets,    4'h0);
    check("run_up_new_val", new_val, 4'h0);
    release_btns();

    // Minute tens: wrap, normal increment, out-of-range
    repeat (3) begin press_mode(); release_btns(); end
    minT_q = 4'd5;
    press_up();
    check("mt_wrap_sets",    sets,    4'b0010);
    check("mt_wrap_new_val", new_val, 4'h0);
    release_btns();
    check("mt_strobe_one_cycle", sets,    4'h0);
    check("mt_new_val_idle",     new_val, 4'h0);
    minT_q = 4'd3;
    press_up();
    check("mt_inc_sets",    sets,    4'b0010);
    check("mt_inc_new_val", new_val, 4'h4);
    release_btns();
    minT_q = 4'd7;
    press_up();
    check("mt_oor_new_val", new_val, 4'h0);
    release_btns();

    // Minute units
    press_mode(); release_btns();
    minU_q = 4'd9;
    press_up();
    check("mu_wrap_sets",    sets,    4'b0001);
    check("mu_wrap_new_val", new_val, 4'h0);
    release_btns();
    minU_q = 4'd4;
    press_up();
    check("mu_inc_new_val", new_val, 4'h5);
    release_btns();
    press_mode();
    check("mu_exit_run_en", 4'(run_en), 4'h1);
    release_btns();

    // Hour tens wrap, then entry fix-up into hour units
    hrT_q = 4'd2; hrU_q = 4'd7;
    press_mode(); release_btns();
    press_up();
    check("ht_wrap_sets",    sets,    4'b1000);
    check("ht_wrap_new_val", new_val, 4'h0);
    release_btns();
    press_mode();
    check("fixup_sets",    sets,    4'b0100);
    check("fixup_new_val", new_val, 4'h3);
    check("fixup_blank",   blank,   4'h0);
    release_btns();
    check("fixup_one_cycle", sets, 4'h0);
    hrU_q = 4'd3;
    press_up();
    check("hu20_wrap_sets",    sets,    4'b0100);
    check("hu20_wrap_new_val", new_val, 4'h0);
    release_btns();
    hrT_q = 4'd1; hrU_q = 4'd5;
    press_up();
    check("hu_inc_new_val", new_val, 4'h6);
    release_btns();

    // Mode and up together: mode wins, no strobe
    mode_btn = 1'b1; up_btn = 1'b1;
    @(negedge clk);
    check("both_sets",    sets,    4'h0);
    check("both_new_val", new_val, 4'h0);
    release_btns();
    do_tick();
    check("both_state_mt", blank, 4'b0010);

    // Timeout out of minute units after 16 ticks
    press_mode(); release_btns();
    for (int i = 1; i <= 15; i++) begin
      do_tick();
      check("to_blank",  blank, (i % 2 == 1) ? 4'b0001 : 4'b0000);
      check("to_run_en", 4'(run_en), 4'h0);
      cyc(1);
    end
    do_tick();
    check("to_not_early", 4'(run_en), 4'h0);
    cyc(1);
    check("to_exit_run_en", 4'(run_en), 4'h1);
    check("to_exit_blank",  blank,      4'h0);
    check("to_exit_sets",   sets,       4'h0);

    // Up edge in the timeout cycle keeps the block in edit
    press_mode(); release_btns();
    for (int i = 1; i <= 15; i++) begin
      do_tick();
      cyc(1);
    end
    do_tick();
    up_btn = 1'b1;
    @(negedge clk);
    check("to_up_sets",    sets,       4'b1000);
    check("to_up_new_val", new_val,    4'h2);
    check("to_up_run_en",  4'(run_en), 4'h0);
    release_btns();
    cyc(3);
    check("to_up_stays_edit", 4'(run_en), 4'h0);

    // Asynchronous reset with a fix-up strobe in flight
    hrT_q = 4'd2; hrU_q = 4'd7;
    press_mode();
    check("pre_rst_sets", sets, 4'b0100);
    up_btn = 1'b1;
    #2 resetn = 1'b0;
    #1;
    check("arst_sets",    sets,       4'h0);
    check("arst_new_val", new_val,    4'h0);
    check("arst_run_en",  4'(run_en), 4'h1);
    check("arst_blank",   blank,      4'h0);
    @(negedge clk);
    resetn = 1'b1;
    cyc(1);
    check("held_sets_1",   sets,       4'h0);
    check("held_run_en_1", 4'(run_en), 4'h1);
    cyc(3);
    check("held_sets_2",   sets,       4'h0);
    check("held_run_en_2", 4'(run_en), 4'h1);
    release_btns();
    press_mode();
    check("post_rst_edit", 4'(run_en), 4'h0);
    release_btns();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
